// File: rtl/nx_node_router.sv
// rtl/nx_node_router.sv - mesh node router: buffered inbound links, RR crossbar, registered egress
// Optional per-destination delivery counters are built when NX_NODE_ROUTER_STATS_EN is defined.

package NXConstants;
  localparam int unsigned MESSAGE_WIDTH = 32;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] column;
  } node_id_t;

  typedef enum logic [1:0] {
    NODE_COMMAND_LOAD    = 2'd0,
    NODE_COMMAND_SIGNAL  = 2'd1,
    NODE_COMMAND_TRACE   = 2'd2,
    NODE_COMMAND_CONTROL = 2'd3
  } node_command_t;

  typedef struct packed {
    node_id_t      target;
    node_command_t command;
    logic [21:0]   payload;
  } node_message_t;
endpackage

module nx_node_router
  import NXConstants::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ROUTE_MODE = 0,
  parameter int MSG_W      = MESSAGE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  node_id_t              i_node_id,
  output logic                  o_idle,
  input  logic [3:0][MSG_W-1:0] i_inbound_data,
  input  logic [3:0]            i_inbound_valid,
  output logic [3:0]            o_inbound_ready,
  output logic [3:0][MSG_W-1:0] o_outbound_data,
  output logic [3:0]            o_outbound_valid,
  input  logic [3:0]            i_outbound_ready,
  input  logic [3:0]            i_outbound_present,
  input  logic [MSG_W-1:0]      i_local_data,
  input  logic                  i_local_valid,
  output logic                  o_local_ready,
  output logic [MSG_W-1:0]      o_dcd_data,
  output logic                  o_dcd_valid,
  input  logic                  i_dcd_ready
`ifdef NX_NODE_ROUTER_STATS_EN
  ,
  output logic [4:0][15:0]      o_stat_fwd
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_E = 3'd1;
  localparam logic [2:0] DIR_S = 3'd2;
  localparam logic [2:0] DIR_W = 3'd3;
  localparam logic [2:0] DIR_L = 3'd4;

  // One clockwise step when the preferred neighbour does not exist.
  function automatic logic [2:0] fallback(input logic [2:0] dir, input logic [3:0] present);
    logic [2:0] res;
    res = dir;
    if (!present[dir[1:0]]) begin
      case (dir)
        DIR_N:   res = DIR_E;
        DIR_E:   res = DIR_S;
        DIR_S:   res = DIR_W;
        default: res = DIR_N;
      endcase
    end
    return res;
  endfunction

  function automatic logic [2:0] route_dest(input logic [MSG_W-1:0] msg, input node_id_t id,
                                            input logic [3:0] present);
    node_message_t hdr;
    logic [2:0]    row_dir;
    logic [2:0]    col_dir;
    logic [2:0]    dir;
    logic          row_mis;
    logic          col_mis;
    hdr     = node_message_t'(msg[MSG_W-1 -: MESSAGE_WIDTH]);
    row_dir = (hdr.target.row < id.row) ? DIR_N : DIR_S;
    col_dir = (hdr.target.column < id.column) ? DIR_W : DIR_E;
    row_mis = (hdr.target.row != id.row);
    col_mis = (hdr.target.column != id.column);
    if (ROUTE_MODE == 0) dir = row_mis ? row_dir : col_dir;
    else                 dir = col_mis ? col_dir : row_dir;
    if (hdr.command == NODE_COMMAND_TRACE) begin
      return present[2] ? DIR_S : DIR_W;
    end
    if (!row_mis && !col_mis) begin
      return DIR_L;
    end
    return fallback(dir, present);
  endfunction

  logic [MSG_W-1:0] fifo_q    [4][FIFO_DEPTH];
  logic [MSG_W-1:0] fifo_d    [4][FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q  [4];
  logic [PW-1:0]    wr_ptr_d  [4];
  logic [PW-1:0]    rd_ptr_q  [4];
  logic [PW-1:0]    rd_ptr_d  [4];
  logic [CW-1:0]    count_q   [4];
  logic [CW-1:0]    count_d   [4];
  logic [4:0]       hold_valid_q;
  logic [4:0]       hold_valid_d;
  logic [MSG_W-1:0] hold_data_q [5];
  logic [MSG_W-1:0] hold_data_d [5];
  logic [2:0]       rr_ptr_q;
  logic [2:0]       rr_ptr_d;

  logic [3:0]       push;
  logic [3:0]       pop;
  logic [4:0]       req_valid;
  logic [4:0]       out_ready;
  logic [4:0]       hold_free;
  logic [4:0]       eligible;
  logic [MSG_W-1:0] req_data [5];
  logic [2:0]       req_dest [5];
  logic             gnt_valid;
  logic [2:0]       gnt_idx;
  logic [2:0]       gnt_dest;
  logic [3:0]       cand;

  always_comb begin
    o_inbound_ready = '0;
    push            = '0;
    req_valid       = '0;
    out_ready       = {i_dcd_ready, i_outbound_ready};
    hold_free       = ~hold_valid_q | out_ready;
    eligible        = '0;
    for (int d = 0; d < 4; d++) begin
      // Ready reflects registered occupancy only; a same-cycle pop does not reopen a full FIFO.
      o_inbound_ready[d] = (count_q[d] != CW'(FIFO_DEPTH)) && !i_rst;
      push[d]            = i_inbound_valid[d] && o_inbound_ready[d];
      req_valid[d]       = (count_q[d] != '0);
      req_data[d]        = fifo_q[d][rd_ptr_q[d]];
    end
    req_valid[4] = i_local_valid;
    req_data[4]  = i_local_data;
    for (int r = 0; r < 5; r++) begin
      req_dest[r] = route_dest(req_data[r], i_node_id, i_outbound_present);
      eligible[r] = req_valid[r] && hold_free[req_dest[r]] && !i_rst;
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < 5; i++) begin
      cand = 4'(rr_ptr_q) + 4'(i);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!gnt_valid && eligible[cand[2:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
    gnt_dest = req_dest[gnt_idx];
    for (int d = 0; d < 4; d++) begin
      pop[d] = gnt_valid && (gnt_idx == 3'(d));
    end
    o_local_ready = gnt_valid && (gnt_idx == DIR_L);
    rr_ptr_d      = rr_ptr_q;
    if (gnt_valid) rr_ptr_d = (gnt_idx == 3'd4) ? 3'd0 : gnt_idx + 3'd1;
  end

  always_comb begin
    fifo_d = fifo_q;
    for (int d = 0; d < 4; d++) begin
      wr_ptr_d[d] = wr_ptr_q[d] + PW'(push[d]);
      rd_ptr_d[d] = rd_ptr_q[d] + PW'(pop[d]);
      count_d[d]  = count_q[d] + CW'(push[d]) - CW'(pop[d]);
      if (push[d]) fifo_d[d][wr_ptr_q[d]] = i_inbound_data[d];
    end
  end

  // Holding registers drain and reload in the same cycle for full throughput.
  always_comb begin
    hold_valid_d = hold_valid_q & ~out_ready;
    hold_data_d  = hold_data_q;
    if (gnt_valid) begin
      hold_valid_d[gnt_dest] = 1'b1;
      hold_data_d[gnt_dest]  = req_data[gnt_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int d = 0; d < 4; d++) begin
        wr_ptr_q[d] <= '0;
        rd_ptr_q[d] <= '0;
        count_q[d]  <= '0;
      end
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    fifo_q      <= fifo_d;
    hold_data_q <= hold_data_d;
  end

  always_comb begin
    o_outbound_valid = hold_valid_q[3:0];
    for (int d = 0; d < 4; d++) o_outbound_data[d] = hold_data_q[d];
    o_dcd_valid = hold_valid_q[4];
    o_dcd_data  = hold_data_q[4];
    o_idle      = !i_local_valid && (hold_valid_q == '0);
    for (int d = 0; d < 4; d++) begin
      if (count_q[d] != '0) o_idle = 1'b0;
    end
  end

`ifdef NX_NODE_ROUTER_STATS_EN
  logic [15:0] stat_q [5];
  logic [15:0] stat_d [5];

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      stat_d[k] = stat_q[k];
      if (hold_valid_q[k] && out_ready[k] && (stat_q[k] != 16'hFFFF)) stat_d[k] = stat_q[k] + 16'd1;
      o_stat_fwd[k] = stat_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 5; k++) stat_q[k] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end
`endif

endmodule
